stream_demux3: RTL and testbench

STREAM_DEMUX3 -- requirements
Module: stream_demux3

---
 rtl/stream_demux3.sv | 132 +++++++++++++
 tb/tb_stream_demux3.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux3.sv
// One-to-three stream demultiplexer. Each channel has a 2-entry FIFO and in_sel=11
// discards the word. drop_count counts discarded words and saturates.
module stream_demux3 #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_valid2,
    input  logic             out_ready0,
    input  logic             out_ready1,
    input  logic             out_ready2,
    output logic [7:0]       drop_count
);

    localparam int unsigned NCH    = 3;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned DROP_W = 8;

    logic [NCH-1:0]    out_ready_v;
    logic [NCH-1:0]    full_v;
    logic [NCH-1:0]    nonempty_v;
    logic [NCH-1:0]    push_v;
    logic [WIDTH-1:0]  head [NCH];
    logic              accept;
    logic              drop_acc;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;

    assign out_ready_v = {out_ready2, out_ready1, out_ready0};

    // Readiness depends only on the occupancy of the selected queue, never on pops.
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            2'd0:    in_ready = ~full_v[0];
            2'd1:    in_ready = ~full_v[1];
            2'd2:    in_ready = ~full_v[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign accept   = in_valid & in_ready;
    assign drop_acc = accept & (in_sel == 2'd3);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [WIDTH-1:0] mem_d [DEPTH];
        logic             rd_ptr_q;
        logic             rd_ptr_d;
        logic             wr_ptr_q;
        logic             wr_ptr_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             pop;

        assign push_v[i]     = accept & (in_sel == 2'(i));
        assign pop           = (cnt_q != '0) & out_ready_v[i];
        assign full_v[i]     = (cnt_q == CNT_W'(DEPTH));
        assign nonempty_v[i] = (cnt_q != '0);
        assign head[i]       = mem_q[rd_ptr_q];

        always_comb begin
            mem_d    = mem_q;
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            cnt_d    = cnt_q;
            if (push_v[i]) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push_v[i], pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    mem_q[k] <= '0;
                end
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                mem_q    <= mem_d;
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                cnt_q    <= cnt_d;
            end
        end
    end

    // Saturating discard counter.
    always_comb begin
        drop_d = drop_q;
        if (drop_acc && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign out_data0  = head[0];
    assign out_data1  = head[1];
    assign out_data2  = head[2];
    assign out_valid0 = nonempty_v[0];
    assign out_valid1 = nonempty_v[1];
    assign out_valid2 = nonempty_v[2];
    assign drop_count = drop_q;

endmodule

// File: tb/tb_stream_demux3.sv
// Scoreboard bench for stream_demux3. Directed stimulus queues the expected words,
// and a negedge monitor checks each word as the consumer takes it.
module tb_stream_demux3;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_data0, out_data1, out_data2;
    logic        out_valid0, out_valid1, out_valid2;
    logic        out_ready0, out_ready1, out_ready2;
    logic [7:0]  drop_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [23:0] exp_q [3][$];
    logic [23:0] od [3];
    logic [2:0]  ov;
    logic [2:0]  ordy;
    logic [23:0] mon_exp;

    always #5 clk = ~clk;

    stream_demux3 #(.WIDTH(24), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_valid0 (out_valid0),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .out_ready0 (out_ready0),
        .out_ready1 (out_ready1),
        .out_ready2 (out_ready2),
        .drop_count (drop_count)
    );

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign ov    = {out_valid2, out_valid1, out_valid0};
    assign ordy  = {out_ready2, out_ready1, out_ready0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word for one cycle; record it as expected if it should be taken.
    task automatic offer(input logic [23:0] d, input logic [1:0] s, input logic exp_rdy);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        @(negedge clk);
        chk($sformatf("in_ready sel%0d data %0h", s, d), 32'(in_ready), 32'(exp_rdy));
        if (exp_rdy && (s != 2'd3)) exp_q[s].push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                if (ov[c] && ordy[c]) begin
                    if (exp_q[c].size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL ch%0d unexpected word: got 0x%0h, expected none", c, od[c]);
                    end else begin
                        mon_exp = exp_q[c].pop_front();
                        chk($sformatf("ch%0d data", c), 32'(od[c]), 32'(mon_exp));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0;
        out_ready0 = 1'b0; out_ready1 = 1'b0; out_ready2 = 1'b0;

        // Reset: in_ready high for every select while rst is held.
        step();
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("rst in_ready sel%0d", s), 32'(in_ready), 32'd1);
        end
        in_sel = 2'd0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst valid", 32'(ov), 32'd0);
        chk("rst data0", 32'(out_data0), 32'd0);
        chk("rst data1", 32'(out_data1), 32'd0);
        chk("rst data2", 32'(out_data2), 32'd0);
        chk("rst drop", 32'(drop_count), 32'd0);
        step();

        // Single route to channel 1.
        out_ready1 = 1'b1;
        offer(24'h00ABCD, 2'd1, 1'b1);
        @(negedge clk);
        chk("route valid", 32'(ov), 32'b010);
        chk("route data1", 32'(out_data1), 32'h00ABCD);
        step();
        out_ready1 = 1'b0;
        @(negedge clk);
        chk("route valid after pop", 32'(ov), 32'd0);
        step();

        // Backpressure on full channel 0.
        offer(24'h000001, 2'd0, 1'b1);
        offer(24'h000002, 2'd0, 1'b1);
        in_data = 24'h000003; in_sel = 2'd0; in_valid = 1'b1;
        @(negedge clk);
        chk("full in_ready sel0", 32'(in_ready), 32'd0);
        in_valid = 1'b0; in_sel = 2'd2;
        #1;
        chk("full in_ready sel2", 32'(in_ready), 32'd1);
        chk("full head0", 32'(out_data0), 32'h000001);
        step();

        // Full-queue pop: no accept while full, accept on the next cycle.
        in_valid = 1'b1; in_sel = 2'd0; in_data = 24'h000003; out_ready0 = 1'b1;
        @(negedge clk);
        chk("pop-full in_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("after pop in_ready", 32'(in_ready), 32'd1);
        exp_q[0].push_back(24'h000003);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("order head0", 32'(out_data0), 32'h000003);
        step();
        out_ready0 = 1'b0;
        @(negedge clk);
        chk("ch0 drained", 32'(ov), 32'd0);
        step();

        // Push and pop together at occupancy 1 on channel 2.
        offer(24'h0000A1, 2'd2, 1'b1);
        out_ready2 = 1'b1;
        offer(24'h0000B2, 2'd2, 1'b1);
        out_ready2 = 1'b0;
        @(negedge clk);
        chk("pp valid", 32'(ov), 32'b100);
        chk("pp head2", 32'(out_data2), 32'h0000B2);
        step();
        offer(24'h0000C3, 2'd2, 1'b1);
        in_sel = 2'd2;
        @(negedge clk);
        chk("pp full in_ready", 32'(in_ready), 32'd0);
        step();
        out_ready2 = 1'b1;
        step();
        step();
        out_ready2 = 1'b0;
        @(negedge clk);
        chk("ch2 drained", 32'(ov), 32'd0);
        step();

        // Three pops alongside one push.
        offer(24'h000010, 2'd0, 1'b1);
        offer(24'h000020, 2'd1, 1'b1);
        offer(24'h000030, 2'd2, 1'b1);
        out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
        offer(24'h000021, 2'd1, 1'b1);
        out_ready0 = 1'b0; out_ready1 = 1'b0; out_ready2 = 1'b0;
        @(negedge clk);
        chk("3pop valid", 32'(ov), 32'b010);
        chk("3pop head1", 32'(out_data1), 32'h000021);
        step();
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        @(negedge clk);
        chk("ch1 drained", 32'(ov), 32'd0);
        step();

        // Drop saturation.
        for (int i = 0; i < 300; i++) begin
            offer(24'(i), 2'd3, 1'b1);
            if (i == 253) chk("drop 254", 32'(drop_count), 32'd254);
            if (i == 254) chk("drop 255", 32'(drop_count), 32'd255);
        end
        @(negedge clk);
        chk("drop sat", 32'(drop_count), 32'd255);
        chk("drop valid", 32'(ov), 32'd0);
        step();

        // Mid-operation reset with words queued and one in flight.
        offer(24'h000111, 2'd0, 1'b1);
        offer(24'h000222, 2'd0, 1'b1);
        offer(24'h000333, 2'd2, 1'b1);
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd1; in_data = 24'h000444;
        step();
        rst = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 3; c++) exp_q[c].delete();
        @(negedge clk);
        chk("mrst valid", 32'(ov), 32'd0);
        chk("mrst data0", 32'(out_data0), 32'd0);
        chk("mrst data1", 32'(out_data1), 32'd0);
        chk("mrst data2", 32'(out_data2), 32'd0);
        chk("mrst drop", 32'(drop_count), 32'd0);
        step();
        @(negedge clk);
        chk("mrst no accept", 32'(ov), 32'd0);
        step();

        for (int c = 0; c < 3; c++) begin
            chk($sformatf("ch%0d leftover", c), 32'(exp_q[c].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
